seq_alu: RTL
============

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU for the datapath; replaces the combinational ALU.
//   Logic, add/sub and shift/rotate ops finish in 1 cycle. Signed MUL (radix-2 Booth) and
//   signed DIV (non-restoring) run iteratively. Results go to a HI:LO pair for the HI/LO regs.
//   A start/busy/done handshake lets the control unit stall on multi-cycle ops.
// PARAMETERS
//   WIDTH     32  operand width; power of two, >= 8
//   OPCODE_W  5   opcode field width (full 5-bit CPU opcode, no truncation)
// PORTS
//   clock         in   1         rising-edge clock
//   clear         in   1         asynchronous, active-high reset
//   start         in   1         launch op; sampled only when busy==0
//   operation     in   OPCODE_W  opcode, captured with start
//   A, B          in   WIDTH     operands, captured with start
//   busy          out  1         op in flight; start ignored while high
//   done          out  1         1-cycle pulse: result_hi/lo valid
//   result_lo     out  WIDTH     result / MUL low word / DIV quotient
//   result_hi     out  WIDTH     MUL high word / DIV remainder / 0 otherwise
//   div_by_zero   out  1         set with done when DIV and B==0
//   illegal_op    out  1         set with done for an unlisted opcode
// BEHAVIOUR
//   Opcodes: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001,
//     AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
//   Reset (clear=1, any time, mid-op included): state IDLE. All outputs 0. Internal regs 0.
//   FSM states: IDLE, MUL, DIV, DIVFIX, DONE.
//     IDLE  -> DONE when start and a 1-cycle op, an illegal op, or DIV with B==0.
//     IDLE  -> MUL when start and MUL. IDLE -> DIV when start and DIV with B!=0.
//     MUL   -> DONE after WIDTH iterations.
//     DIV   -> DIVFIX after WIDTH iterations. DIVFIX -> DONE.
//     DONE  -> IDLE. done=1 for exactly this cycle.
//   busy=1 from the cycle after an accepted start through the DONE cycle.
//   Latency (start sampled at edge t, done high after edge):
//     1-cycle op t+1; MUL t+WIDTH+1; DIV t+WIDTH+2.
//   result_hi/lo, div_by_zero and illegal_op update on entry to DONE.
//     They hold until the next DONE or clear.
//   Arithmetic rules:
//     ADD/SUB/NEG wrap modulo 2^WIDTH. result_hi=0.
//     Shifts/rotates use B[$clog2(WIDTH)-1:0] as the amount. Amount 0 passes A unchanged.
//     SHRA sign-fills.
//   MUL: signed A*B, 2*WIDTH-bit product; result_hi = upper word, result_lo = lower word.
//     Example: MIN*MIN = 2^(2*WIDTH-2).
//   DIV: signed; quotient truncates toward zero; remainder takes the dividend's sign.
//     MIN / -1 gives result_lo = MIN, result_hi = 0 (no flag).
//   DIV with B==0 gives result_lo = all ones, result_hi = A, div_by_zero=1.
//   Illegal opcode gives result_lo = result_hi = 0, illegal_op=1.
//   start while busy is ignored (no queueing). Operands are latched, so later A/B changes have no effect.
//   start together with clear: clear wins.
// STRUCTURE
//   Shared package alu_pkg:
//     localparam opcodes OP_ADD..OP_NOT (OPCODE_W bits)
//     typedef alu_state_t {IDLE, MUL, DIV, DIVFIX, DONE}
//     function is_single_cycle(op)
//   One sub-module: alu_iter_divider (signed non-restoring divider).
//     Ports: load/step/fix, quotient, remainder.
//     The top holds the FSM, the Booth MUL datapath and the combinational single-cycle ops.
// TESTING
//   1 ADD 0x7FFFFFFF+1: result_lo=0x80000000, hi=0, done at t+1.
//     SUB 0-1: 0xFFFFFFFF.
//   2 SHRA A=0x80000010, B=4: result_lo=0xF8000001.
//     ROL A=0x80000001, B=1: 0x00000003.
//     SHL by 0: A unchanged.
//   3 MUL -3*7: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done exactly at t+33.
//     Same op 0x80000000*0x80000000: hi=0x40000000, lo=0.
//   4 DIV -7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF, done at t+34.
//     DIV 0x80000000/-1: lo=0x80000000, hi=0.
//   5 DIV 5/0: done at t+1, div_by_zero=1, lo=0xFFFFFFFF, hi=5.
//     Opcode 11111: illegal_op=1, outputs 0.
//   6 Pulse start mid-MUL: result must be unchanged.
//     Assert clear at iteration 10: outputs 0, busy=0 immediately.
//     Next ADD 2+3 = 5 at t+1.
//     Sweep WIDTH=8 and 16 against a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op classification shared by the seq_alu files
package alu_pkg;
    localparam int OPW = 5;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPW-1:0] OP_AND  = 5'b01010;
    localparam logic [OPW-1:0] OP_OR   = 5'b01011;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    typedef enum logic [2:0] {IDLE, MUL, DIV, DIVFIX, DONE} alu_state_t;
    function automatic logic is_single_cycle(input logic [OPW-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                          OP_AND, OP_OR, OP_NEG, OP_NOT};
    endfunction
endpackage

// File: rtl/alu_iter_divider.sv
// alu_iter_divider: signed non-restoring divider working on operand magnitudes,
// one quotient bit per step; outputs carry the sign-corrected quotient/remainder.
module alu_iter_divider import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo, r_den;
    logic             r_nq, r_nr;
    logic [WIDTH-1:0] w_ma, w_mb;
    logic [WIDTH:0]   w_sh, w_nxt, w_fix;
    assign w_ma = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_mb = divisor[WIDTH-1] ? -divisor : divisor;
    assign w_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    // partial remainder sign picks add or subtract; quotient bit is the new sign inverted
    assign w_nxt = r_rem[WIDTH] ? w_sh + {1'b0, r_den} : w_sh - {1'b0, r_den};
    assign w_fix = r_rem[WIDTH] ? r_rem + {1'b0, r_den} : r_rem;
    assign quotient = r_nq ? -r_quo : r_quo;
    assign remainder = r_nr ? -w_fix[WIDTH-1:0] : w_fix[WIDTH-1:0];
    always_ff @(posedge clock or posedge clear)
        if (clear) begin
            r_rem <= '0;
            r_quo <= '0;
            r_den <= '0;
            r_nq  <= 1'b0;
            r_nr  <= 1'b0;
        end else if (load) begin
            r_rem <= '0;
            r_quo <= w_ma;
            r_den <= w_mb;
            r_nq  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_nr  <= dividend[WIDTH-1];
        end else if (step) begin
            r_rem <= w_nxt;
            r_quo <= {r_quo[WIDTH-2:0], ~w_nxt[WIDTH]};
        end else if (fix) begin
            r_rem <= w_fix;
        end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU; single-cycle logic/arith/shift ops, radix-2 Booth MUL,
// iterative DIV, with a start/busy/done handshake and a held HI:LO result pair.
module seq_alu import alu_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int OPCODE_W = OPW
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OPCODE_W-1:0] operation,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result_lo,
    output logic [WIDTH-1:0]    result_hi,
    output logic                div_by_zero,
    output logic                illegal_op
);
    localparam int SW = $clog2(WIDTH);
    alu_state_t       r_state, w_next;
    logic [SW-1:0]    r_cnt, w_amt, w_namt;
    logic [WIDTH:0]   r_acc, w_sum;
    logic [WIDTH-1:0] r_m, r_bq, w_lo, w_hi, w_quo, w_rem;
    logic             r_q1, w_ill, w_dz, w_legal, w_mul, w_div, w_last;
    logic [OPW-1:0]   w_op;
    assign w_op = operation[OPW-1:0];
    assign w_legal = (operation >> OPW) == '0;
    assign w_mul = w_legal && w_op == OP_MUL;
    assign w_div = w_legal && w_op == OP_DIV;
    assign w_amt = B[SW-1:0];
    assign w_namt = -w_amt;
    assign w_last = r_cnt == SW'(WIDTH - 1);
    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
    // Booth recoding of {multiplier bit, previous bit}; one guard bit absorbs -MIN
    assign w_sum = ({r_bq[0], r_q1} == 2'b01) ? r_acc + {r_m[WIDTH-1], r_m} :
                   ({r_bq[0], r_q1} == 2'b10) ? r_acc - {r_m[WIDTH-1], r_m} : r_acc;
    always_comb begin
        w_lo = '0;
        w_hi = '0;
        w_ill = 1'b0;
        w_dz = 1'b0;
        if (!w_legal || !(is_single_cycle(w_op) || w_mul || w_div))
            w_ill = 1'b1;
        else
            case (w_op)
                OP_ADD:  w_lo = A + B;
                OP_SUB:  w_lo = A - B;
                OP_SHR:  w_lo = A >> w_amt;
                OP_SHRA: w_lo = $signed(A) >>> w_amt;
                OP_SHL:  w_lo = A << w_amt;
                OP_ROR:  w_lo = (A >> w_amt) | (A << w_namt);
                OP_ROL:  w_lo = (A << w_amt) | (A >> w_namt);
                OP_AND:  w_lo = A & B;
                OP_OR:   w_lo = A | B;
                OP_NEG:  w_lo = -A;
                OP_NOT:  w_lo = ~A;
                OP_DIV: begin
                    w_lo = '1;
                    w_hi = A;
                    w_dz = 1'b1;
                end
                default: w_lo = '0;
            endcase
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_mul ? MUL : (w_div && B != '0) ? DIV : DONE;
            MUL:     if (w_last) w_next = DONE;
            DIV:     if (w_last) w_next = DIVFIX;
            DIVFIX:  w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge clear)
        if (clear) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_m         <= '0;
            r_bq        <= '0;
            r_q1        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_cnt <= '0;
                r_acc <= '0;
                r_m   <= A;
                r_bq  <= B;
                r_q1  <= 1'b0;
                if (w_next == DONE) begin
                    result_lo   <= w_lo;
                    result_hi   <= w_hi;
                    div_by_zero <= w_dz;
                    illegal_op  <= w_ill;
                end
            end else if (r_state == MUL) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                r_bq  <= {w_sum[0], r_bq[WIDTH-1:1]};
                r_q1  <= r_bq[0];
                if (w_last) begin
                    result_hi   <= w_sum[WIDTH:1];
                    result_lo   <= {w_sum[0], r_bq[WIDTH-1:1]};
                    div_by_zero <= 1'b0;
                    illegal_op  <= 1'b0;
                end
            end else if (r_state == DIV) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == DIVFIX) begin
                result_lo   <= w_quo;
                result_hi   <= w_rem;
                div_by_zero <= 1'b0;
                illegal_op  <= 1'b0;
            end
        end
    alu_iter_divider #(.WIDTH(WIDTH)) u_div (
        .clock    (clock),
        .clear    (clear),
        .load     (r_state == IDLE && start),
        .step     (r_state == DIV),
        .fix      (r_state == DIVFIX),
        .dividend (A),
        .divisor  (B),
        .quotient (w_quo),
        .remainder(w_rem)
    );
endmodule
